// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronize, debounce, edge-detect
// and auto-repeat each key channel independently.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          key_sync;
    logic [DW-1:0] db_q;
    logic [DW-1:0] db_d;
    logic          p_q;
    logic          p_d;
    logic          rise;
    logic          pp_q;
    rpt_state_t    st_q;
    rpt_state_t    st_d;
    logic [RW-1:0] rc_q;
    logic [RW-1:0] rc_d;
    logic          rp_q;
    logic          rp_d;

    assign key_sync = ~sync2;
    assign rise     = p_d & ~p_q;

    // Two-flop synchronizer; reset parks it at "released".
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= keys_n[i];
        sync2 <= sync1;
      end
    end

    // Debounce: count consecutive mismatch cycles, toggle on the last.
    always_comb begin
      p_d  = p_q;
      db_d = '0;
      if (key_sync != p_q) begin
        if (db_q == DB_LAST) begin
          p_d = ~p_q;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
    end

    // Repeat FSM next state; a release always wins over a terminal count.
    always_comb begin
      st_d = st_q;
      rc_d = rc_q;
      rp_d = 1'b0;
      if (!p_d) begin
        st_d = IDLE;
        rc_d = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            if (rise) begin
              st_d = DELAY;
              rc_d = '0;
              rp_d = 1'b1;
            end
          end
          DELAY: begin
            if (rc_q == DLY_LAST) begin
              st_d = REPEAT;
              rc_d = '0;
              rp_d = 1'b1;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rc_q == PER_LAST) begin
              rc_d = '0;
              rp_d = 1'b1;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
          default: begin
            st_d = IDLE;
            rc_d = '0;
          end
        endcase
      end
    end

    // Channel state registers and registered pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_q <= '0;
        p_q  <= 1'b0;
        pp_q <= 1'b0;
        st_q <= IDLE;
        rc_q <= '0;
        rp_q <= 1'b0;
      end else begin
        db_q <= db_d;
        p_q  <= p_d;
        pp_q <= rise;
        st_q <= st_d;
        rc_q <= rc_d;
        rp_q <= rp_d;
      end
    end

    assign pressed[i]      = p_q;
    assign press_pulse[i]  = pp_q;
    assign repeat_pulse[i] = rp_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random bounce,
// all outputs compared each cycle against a behavioural model.
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] keys_n = '1;
  logic [N-1:0] pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] repeat_pulse;

  int checks = 0;
  int failures = 0;

  int m_s1[N];
  int m_s2[N];
  int m_p[N];
  int m_run[N];
  int m_pp[N];
  int m_rp[N];
  int m_pt[N];
  int cyc = 0;

  key_conditioner #(
    .NUM_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys_n(keys_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_s1[k] = 1;
      m_s2[k] = 1;
      m_p[k] = 0;
      m_run[k] = 0;
      m_pp[k] = 0;
      m_rp[k] = 0;
      m_pt[k] = 0;
    end
  endtask

  // Reference: a level is accepted after D consecutive differing
  // synchronized samples; repeats follow press time arithmetic.
  task automatic model_edge();
    int ks;
    int d;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    for (int k = 0; k < N; k++) begin
      ks = (m_s2[k] == 0) ? 1 : 0;
      m_s2[k] = m_s1[k];
      m_s1[k] = int'(keys_n[k]);
      m_pp[k] = 0;
      if (ks != m_p[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_p[k] = ks;
          m_run[k] = 0;
          if (ks == 1) begin
            m_pp[k] = 1;
            m_pt[k] = cyc;
          end
        end
      end else begin
        m_run[k] = 0;
      end
      d = cyc - m_pt[k];
      m_rp[k] = (m_p[k] == 1 &&
                 (d == 0 || (d >= RD && (d - RD) % RP == 0))) ? 1 : 0;
    end
  endtask

  task automatic compare(input string tag);
    logic [N-1:0] ep;
    logic [N-1:0] epp;
    logic [N-1:0] erp;
    for (int k = 0; k < N; k++) begin
      ep[k]  = (m_p[k] != 0);
      epp[k] = (m_pp[k] != 0);
      erp[k] = (m_rp[k] != 0);
    end
    checks++;
    assert (pressed === ep) else begin
      failures++;
      $error("FAIL %s.pressed cyc=%0d got=%b exp=%b", tag, cyc, pressed, ep);
    end
    checks++;
    assert (press_pulse === epp) else begin
      failures++;
      $error("FAIL %s.press_pulse cyc=%0d got=%b exp=%b",
             tag, cyc, press_pulse, epp);
    end
    checks++;
    assert (repeat_pulse === erp) else begin
      failures++;
      $error("FAIL %s.repeat_pulse cyc=%0d got=%b exp=%b",
             tag, cyc, repeat_pulse, erp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic check_bit(input string tag, input logic got,
                           input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int lat;
    int hold[N];
    model_reset();

    // Reset with keys held: no activity.
    keys_n = '0;
    steps(4, "rst_hold");
    keys_n = '1;
    steps(3, "rst_idle");
    #1 reset = 1'b0;
    steps(2, "idle");

    // Key 0 clean press: latency D+2.
    keys_n[0] = 1'b0;
    lat = 0;
    while (lat < 20 && pressed[0] !== 1'b1) begin
      step("k0_press");
      lat++;
    end
    check_int("k0_latency", lat, D + 2);
    check_bit("k0_pp", press_pulse[0], 1'b1);
    steps(14, "k0_hold");

    // Async reset mid-repeat while key 0 stays held.
    reset = 1'b1;
    #1;
    model_reset();
    compare("rst_async");
    steps(2, "rst_mid");
    reset = 1'b0;
    lat = 0;
    while (lat < 20 && press_pulse[0] !== 1'b1) begin
      step("k0_repress");
      lat++;
    end
    check_int("k0_relatency", lat, D + 2);
    keys_n[0] = 1'b1;
    steps(10, "k0_release");

    // Key 1 glitch shorter than debounce window.
    keys_n[1] = 1'b0;
    steps(3, "k1_glitch");
    keys_n[1] = 1'b1;
    steps(10, "k1_after");
    check_bit("k1_never", pressed[1], 1'b0);

    // Key 2 long hold with repeats, then release.
    keys_n[2] = 1'b0;
    steps(40, "k2_hold");
    keys_n[2] = 1'b1;
    steps(5, "k2_rel");
    check_bit("k2_still_held", pressed[2], 1'b1);
    step("k2_rel");
    check_bit("k2_fall", pressed[2], 1'b0);
    steps(4, "k2_idle");

    // Key 3 release landing on a repeat terminal count.
    keys_n[3] = 1'b0;
    lat = 0;
    while (lat < 20 && press_pulse[3] !== 1'b1) begin
      step("k3_press");
      lat++;
    end
    check_int("k3_latency", lat, D + 2);
    steps(10, "k3_hold");
    check_bit("k3_delay_pulse", repeat_pulse[3], 1'b1);
    keys_n[3] = 1'b1;
    steps(D + 2, "k3_rel");
    check_bit("k3_fall", pressed[3], 1'b0);
    check_bit("k3_no_term_pulse", repeat_pulse[3], 1'b0);
    steps(8, "k3_idle");

    // All keys pressed together.
    keys_n = '0;
    steps(D + 2, "all_press");
    checks++;
    assert (press_pulse === 4'b1111) else begin
      failures++;
      $error("FAIL all_pp got=%b exp=1111", press_pulse);
    end
    steps(12, "all_hold");
    keys_n = '1;
    steps(10, "all_rel");

    // Random bounce on every channel.
    for (int k = 0; k < N; k++) hold[k] = $urandom_range(1, 12);
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < N; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          keys_n[k] = ~keys_n[k];
          hold[k] = ($urandom_range(0, 2) == 0) ?
                    $urandom_range(1, 3) : $urandom_range(4, 30);
        end
      end
      step("rand");
    end
    keys_n = '1;
    steps(12, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
